// File: rtl/dram_init_sequencer_if.sv
// Wishbone CSR bus between the DDR3 init sequencer (master) and the DFII
// CSR block (slave). Word-addressed, 32-bit, write-only from the master.
//   wb_adr   : word address
//   wb_dat_w : write data
//   wb_sel   : byte select
//   wb_cyc   : bus cycle
//   wb_stb   : strobe
//   wb_we    : write enable
//   wb_ack   : slave acknowledge
interface dram_init_sequencer_if;
  logic [29:0] wb_adr;
  logic [31:0] wb_dat_w;
  logic [3:0]  wb_sel;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic        wb_ack;

  modport master (
    output wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
    input  wb_ack
  );

  modport slave (
    input  wb_adr, wb_dat_w, wb_sel, wb_cyc, wb_stb, wb_we,
    output wb_ack
  );
endinterface

// File: rtl/dram_init_sequencer.sv
// DDR3 power-up sequencer. Walks a fixed 31-step table of DFII CSR writes
// and timed waits: releases RESET_N, enables CKE, programs MR2/MR3/MR1/MR0,
// issues ZQCL and finally hands the PHY over to the controller.
// Ports:
//   clk    : single clock domain
//   rst_n  : asynchronous active-low reset, aborts any sequence at once
//   start  : 1-cycle pulse, starts the sequence from IDLE/DONE/ERROR
//   busy   : high while sequencing
//   done   : level, set after successful hand-over until next start
//   error  : level, set after an ack timeout until next start
//   step   : current table step 0..30
//   csr    : Wishbone master port (dram_init_sequencer_if.master)
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | out of reset, waiting for start
// WB_REQ  | write of current step on the bus, waiting for ack
// WB_GAP  | one idle bus cycle after an acked write
// WAIT    | timed delay step, counter runs down to zero
// DONE    | sequence complete, PHY handed to controller
// ERROR   | ack timeout, step frozen at failing write
module dram_init_sequencer #(
  parameter logic [29:0] CSR_BASE = 30'h2400,
  parameter logic [31:0] MR0      = 32'h320,
  parameter logic [31:0] MR1      = 32'h6,
  parameter logic [31:0] MR2      = 32'h200,
  parameter logic [31:0] MR3      = 32'h0,
  parameter logic [15:0] T_RSTLOW = 16'd35,
  parameter logic [15:0] T_CKE    = 16'd50,
  parameter logic [15:0] T_XPR    = 16'd20,
  parameter logic [15:0] T_DLLK   = 16'd600,
  parameter logic [15:0] T_ZQINIT = 16'd600,
  parameter logic [15:0] ACK_TMO  = 16'd255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [4:0]                   step,
  dram_init_sequencer_if.master        csr
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WB_REQ = 3'd1,
    WB_GAP = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_t;

  // DFII register word offsets from CSR_BASE
  localparam logic [2:0] OFF_CTRL  = 3'd0;
  localparam logic [2:0] OFF_CMD   = 3'd1;
  localparam logic [2:0] OFF_ISSUE = 3'd2;
  localparam logic [2:0] OFF_ADDR  = 3'd3;
  localparam logic [2:0] OFF_BADDR = 3'd4;

  localparam logic [4:0] LAST_STEP = 5'd30;

  // Wait length of a delay step; zero marks a write step (all T_* >= 1).
  function automatic logic [15:0] wait_len(input logic [4:0] s);
    wait_len = 16'd0;
    case (s)
      5'd1:    wait_len = T_RSTLOW;
      5'd5:    wait_len = T_CKE;
      5'd7:    wait_len = T_XPR;
      5'd24:   wait_len = T_DLLK;
      5'd29:   wait_len = T_ZQINIT;
      default: wait_len = 16'd0;
    endcase
  endfunction

  // {register offset, write data} of a write step.
  function automatic logic [34:0] wr_info(input logic [4:0] s);
    wr_info = {OFF_CTRL, 32'h0};
    case (s)
      5'd0:                          wr_info = {OFF_CTRL,  32'h00};
      5'd2:                          wr_info = {OFF_ADDR,  32'h0};
      5'd3, 5'd21, 5'd26:            wr_info = {OFF_BADDR, 32'h0};
      5'd4:                          wr_info = {OFF_CTRL,  32'h0C};
      5'd6:                          wr_info = {OFF_CTRL,  32'h0E};
      5'd8:                          wr_info = {OFF_ADDR,  MR2};
      5'd9:                          wr_info = {OFF_BADDR, 32'h2};
      5'd12:                         wr_info = {OFF_ADDR,  MR3};
      5'd13:                         wr_info = {OFF_BADDR, 32'h3};
      5'd16:                         wr_info = {OFF_ADDR,  MR1};
      5'd17:                         wr_info = {OFF_BADDR, 32'h1};
      5'd20:                         wr_info = {OFF_ADDR,  MR0};
      5'd25:                         wr_info = {OFF_ADDR,  32'h400};
      5'd10, 5'd14, 5'd18, 5'd22:    wr_info = {OFF_CMD,   32'h0F};
      5'd27:                         wr_info = {OFF_CMD,   32'h03};
      5'd11, 5'd15, 5'd19, 5'd23,
      5'd28:                         wr_info = {OFF_ISSUE, 32'h1};
      5'd30:                         wr_info = {OFF_CTRL,  32'h01};
      default:                       wr_info = {OFF_CTRL,  32'h0};
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [4:0]  step_q, step_d;
  logic [15:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        advance;

  logic [34:0] cur_wr;
  logic [4:0]  step_inc;
  logic [15:0] nxt_wait;
  logic        in_req;

  assign cur_wr   = wr_info(step_q);
  assign step_inc = step_q + 5'd1;
  assign nxt_wait = wait_len(step_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 5'd0;
      cnt_q   <= 16'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // The same down-counter serves as delay timer in WAIT and as ack
  // timeout in WB_REQ; each is reloaded on entry to its state.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = done_q;
    error_d = error_q;
    advance = 1'b0;

    unique case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = WB_REQ;
          step_d  = 5'd0;
          cnt_d   = ACK_TMO - 16'd1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
        end
      end
      WB_REQ: begin
        if (csr.wb_ack) begin
          state_d = WB_GAP;
        end else if (cnt_q == 16'd0) begin
          state_d = ERROR;
          busy_d  = 1'b0;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      WB_GAP: advance = 1'b1;
      WAIT: begin
        if (cnt_q == 16'd0) advance = 1'b1;
        else                cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (step_q == LAST_STEP) begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        step_d = step_inc;
        if (nxt_wait != 16'd0) begin
          state_d = WAIT;
          cnt_d   = nxt_wait - 16'd1;
        end else begin
          state_d = WB_REQ;
          cnt_d   = ACK_TMO - 16'd1;
        end
      end
    end
  end

  // Bus outputs decode straight from the state register so they fall the
  // edge the ack is sampled, and address/data read as zero when idle.
  assign in_req       = (state_q == WB_REQ);
  assign csr.wb_cyc   = in_req;
  assign csr.wb_stb   = in_req;
  assign csr.wb_we    = in_req;
  assign csr.wb_sel   = {4{in_req}};
  assign csr.wb_adr   = in_req ? (CSR_BASE + {27'd0, cur_wr[34:32]}) : 30'd0;
  assign csr.wb_dat_w = in_req ? cur_wr[31:0] : 32'd0;

  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;
  assign step  = step_q;

endmodule

// File: tb/tb_dram_init_sequencer.sv
module tb_dram_init_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic busy_a, done_a, error_a, busy_b, done_b, error_b;
  logic [4:0] step_a, step_b;

  dram_init_sequencer_if bus_a();
  dram_init_sequencer_if bus_b();

  dram_init_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .error(error_a), .step(step_a), .csr(bus_a)
  );

  dram_init_sequencer #(
    .T_RSTLOW(16'd1), .T_CKE(16'd1), .T_XPR(16'd1), .T_DLLK(16'd1), .T_ZQINIT(16'd1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .error(error_b), .step(step_b), .csr(bus_b)
  );

  always #5 clk = ~clk;

  int cyc_no = 0;
  always @(posedge clk) cyc_no <= cyc_no + 1;

  // Observed DUT select and slave model
  logic use_b = 1'b0;
  int   ack_lat = 1;
  int   noack_step = -1;
  int   age = 0;

  logic        m_cyc, m_stb, m_we, m_ack, m_done, m_busy, m_error;
  logic [3:0]  m_sel;
  logic [29:0] m_adr;
  logic [31:0] m_dat;
  logic [4:0]  m_step;

  assign m_cyc   = use_b ? bus_b.wb_cyc   : bus_a.wb_cyc;
  assign m_stb   = use_b ? bus_b.wb_stb   : bus_a.wb_stb;
  assign m_we    = use_b ? bus_b.wb_we    : bus_a.wb_we;
  assign m_sel   = use_b ? bus_b.wb_sel   : bus_a.wb_sel;
  assign m_adr   = use_b ? bus_b.wb_adr   : bus_a.wb_adr;
  assign m_dat   = use_b ? bus_b.wb_dat_w : bus_a.wb_dat_w;
  assign m_step  = use_b ? step_b  : step_a;
  assign m_done  = use_b ? done_b  : done_a;
  assign m_busy  = use_b ? busy_b  : busy_a;
  assign m_error = use_b ? error_b : error_a;

  assign m_ack = m_cyc && m_stb && (age == ack_lat - 1) && (int'(m_step) != noack_step);
  assign bus_a.wb_ack = m_ack && !use_b;
  assign bus_b.wb_ack = m_ack && use_b;

  always @(posedge clk) begin
    if (m_cyc && m_stb && !m_ack) age <= age + 1;
    else                          age <= 0;
  end

  // Bus monitor: logs each acked write with the cycle its request began
  int mon_adr[$];
  int mon_dat[$];
  int mon_start[$];
  int unstable = 0;
  int bad = 0;
  logic        in_xfer = 1'b0;
  logic [29:0] cur_adr;
  logic [31:0] cur_dat;
  int          cur_start = 0;

  always @(negedge clk) begin
    if (m_cyc) begin
      if (m_sel != 4'hF || !m_we || !m_stb) bad <= bad + 1;
      if (in_xfer && (m_adr != cur_adr || m_dat != cur_dat)) unstable <= unstable + 1;
      if (!in_xfer) begin
        cur_adr   <= m_adr;
        cur_dat   <= m_dat;
        cur_start <= cyc_no;
      end
      in_xfer <= !m_ack;
      if (m_ack) begin
        mon_adr.push_back(int'(m_adr));
        mon_dat.push_back(int'(m_dat));
        mon_start.push_back(in_xfer ? cur_start : cyc_no);
      end
    end else begin
      in_xfer <= 1'b0;
      if (m_adr != 30'd0 || m_dat != 32'd0 || m_sel != 4'd0 || m_we || m_stb) bad <= bad + 1;
    end
  end

  // Expected write list, in table order
  int e_adr[26] = '{
    'h2400, 'h2403, 'h2404, 'h2400, 'h2400,
    'h2403, 'h2404, 'h2401, 'h2402,
    'h2403, 'h2404, 'h2401, 'h2402,
    'h2403, 'h2404, 'h2401, 'h2402,
    'h2403, 'h2404, 'h2401, 'h2402,
    'h2403, 'h2404, 'h2401, 'h2402,
    'h2400};
  int e_dat[26] = '{
    'h0, 'h0, 'h0, 'hC, 'hE,
    'h200, 'h2, 'hF, 'h1,
    'h0,   'h3, 'hF, 'h1,
    'h6,   'h1, 'hF, 'h1,
    'h320, 'h0, 'hF, 'h1,
    'h400, 'h0, 'h3, 'h1,
    'h1};

  // Delay that follows write k (0 when another write follows directly)
  function automatic int wait_after(int k, bit b);
    case (k)
      0:       return b ? 1 : 35;
      3:       return b ? 1 : 50;
      4:       return b ? 1 : 20;
      20:      return b ? 1 : 600;
      24:      return b ? 1 : 600;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_start(int k, int lat, bit b);
    int off = 0;
    for (int j = 0; j < k; j++) off += lat + 1 + wait_after(j, b);
    return off;
  endfunction

  int n_chk = 0;
  int n_pass = 0;
  int t0 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic pulse_start(input bit b);
    @(negedge clk);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    t0 = cyc_no;
  endtask

  task automatic wait_flag(input int budget, input int poke_at, output bit seen, output int at);
    seen = 1'b0;
    at = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      start_a = (i == poke_at);
      if (m_done || m_error) begin
        seen = 1'b1;
        at = cyc_no - t0;
        break;
      end
    end
    start_a = 1'b0;
  endtask

  task automatic check_run(input string name, input int lat, input bit b, input int n0, input int nw);
    for (int k = 0; k < nw; k++) begin
      if (n0 + k < mon_adr.size()) begin
        check($sformatf("%s adr[%0d]", name, k), mon_adr[n0+k], e_adr[k]);
        check($sformatf("%s dat[%0d]", name, k), mon_dat[n0+k], e_dat[k]);
        check($sformatf("%s start[%0d]", name, k), mon_start[n0+k] - t0, exp_start(k, lat, b));
      end
    end
  endtask

  initial begin
    bit seen;
    int at, n0, b0, u0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst busy", busy_a, 0);
    check("rst done", done_a, 0);
    check("rst error", error_a, 0);
    check("rst step", step_a, 0);
    check("rst cyc", bus_a.wb_cyc, 0);
    check("rst stb", bus_a.wb_stb, 0);
    check("rst we", bus_a.wb_we, 0);
    check("rst sel", bus_a.wb_sel, 0);
    check("rst adr", bus_a.wb_adr, 0);
    check("rst dat", bus_a.wb_dat_w, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Run 1: ack in first request cycle
    ack_lat = 1;
    n0 = mon_adr.size(); b0 = bad; u0 = unstable;
    pulse_start(1'b0);
    check("r1 first step", step_a, 0);
    check("r1 first busy", busy_a, 1);
    check("r1 first cyc", bus_a.wb_cyc, 1);
    check("r1 first adr", bus_a.wb_adr, 'h2400);
    wait_flag(3000, -1, seen, at);
    check("r1 done seen", seen, 1);
    check("r1 done cycle", at, exp_start(26, 1, 1'b0));
    check("r1 done", done_a, 1);
    check("r1 busy", busy_a, 0);
    check("r1 error", error_a, 0);
    check("r1 step", step_a, 30);
    check("r1 writes", mon_adr.size() - n0, 26);
    check_run("r1", 1, 1'b0, n0, 26);
    check("r1 bus protocol", bad - b0, 0);
    check("r1 stability", unstable - u0, 0);

    // Run 2: 3-cycle ack latency, restart from DONE, start poked while busy
    ack_lat = 3;
    n0 = mon_adr.size(); b0 = bad; u0 = unstable;
    pulse_start(1'b0);
    check("r2 restart done clr", done_a, 0);
    wait_flag(3000, 100, seen, at);
    check("r2 done seen", seen, 1);
    check("r2 done cycle", at, exp_start(26, 3, 1'b0));
    check("r2 step", step_a, 30);
    check("r2 writes", mon_adr.size() - n0, 26);
    check_run("r2", 3, 1'b0, n0, 26);
    check("r2 bus protocol", bad - b0, 0);
    check("r2 stability", unstable - u0, 0);

    // Run 3: slave never acks step 8 -> timeout
    ack_lat = 1;
    noack_step = 8;
    n0 = mon_adr.size();
    pulse_start(1'b0);
    wait_flag(3000, -1, seen, at);
    check("r3 error seen", seen, 1);
    check("r3 error cycle", at, exp_start(5, 1, 1'b0) + 255);
    check("r3 error", error_a, 1);
    check("r3 busy", busy_a, 0);
    check("r3 done", done_a, 0);
    check("r3 step", step_a, 8);
    check("r3 cyc", bus_a.wb_cyc, 0);
    check("r3 writes", mon_adr.size() - n0, 5);
    check_run("r3", 1, 1'b0, n0, 5);
    repeat (5) @(negedge clk);
    check("r3 error held", error_a, 1);
    check("r3 step held", step_a, 8);

    // Run 4: restart from ERROR, then async reset during step 24
    noack_step = -1;
    pulse_start(1'b0);
    check("r4 step", step_a, 0);
    check("r4 busy", busy_a, 1);
    check("r4 error clr", error_a, 0);
    check("r4 adr", bus_a.wb_adr, 'h2400);
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (step_a == 5'd24) begin
        seen = 1'b1;
        break;
      end
    end
    check("r4 reached step 24", seen, 1);
    #3 rst_n = 1'b0;
    #1;
    check("r4 rst busy", busy_a, 0);
    check("r4 rst step", step_a, 0);
    check("r4 rst done", done_a, 0);
    check("r4 rst error", error_a, 0);
    check("r4 rst cyc", bus_a.wb_cyc, 0);
    check("r4 rst adr", bus_a.wb_adr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("r4 idle busy", busy_a, 0);
    check("r4 idle step", step_a, 0);
    check("r4 idle cyc", bus_a.wb_cyc, 0);

    // Run 5: all delays 1 cycle
    use_b = 1'b1;
    n0 = mon_adr.size(); b0 = bad; u0 = unstable;
    pulse_start(1'b1);
    wait_flag(500, -1, seen, at);
    check("r5 done seen", seen, 1);
    check("r5 done cycle", at, exp_start(26, 1, 1'b1));
    check("r5 step", step_b, 30);
    check("r5 error", error_b, 0);
    check("r5 writes", mon_adr.size() - n0, 26);
    check_run("r5", 1, 1'b1, n0, 26);
    check("r5 bus protocol", bad - b0, 0);
    check("r5 stability", unstable - u0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
